// File: rtl/demux2_4_stream.sv
// Registered 1-to-4 valid/ready stream demultiplexer with a one-entry holding slot per channel.
// Define DEMUX2_4_STREAM_CNT_EN to add per-channel 16-bit accept counters (cnt0..cnt3).
module demux2_4_stream #(
    parameter int unsigned BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] in_data,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [BIT_WIDTH-1:0] out0,
    output logic [BIT_WIDTH-1:0] out1,
    output logic [BIT_WIDTH-1:0] out2,
`ifdef DEMUX2_4_STREAM_CNT_EN
    output logic [BIT_WIDTH-1:0] out3,
    output logic [15:0]          cnt0,
    output logic [15:0]          cnt1,
    output logic [15:0]          cnt2,
    output logic [15:0]          cnt3
`else
    output logic [BIT_WIDTH-1:0] out3
`endif
);

    localparam int unsigned NUM_CH = 4;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_e;

    slot_e                      state_q [NUM_CH];
    slot_e                      state_d [NUM_CH];
    logic [NUM_CH-1:0]          load;
    logic                       accept;
    logic [BIT_WIDTH-1:0]       data_q  [NUM_CH];

    // Addressed slot can take a word if it is empty or being drained this cycle.
    assign in_ready = rst_n & (~out_valid[sel] | out_ready[sel]);
    assign accept   = in_valid & in_ready;

    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            state_d[i] = state_q[i];
            load[i]    = 1'b0;
            if (accept && (sel == 2'(i))) begin
                load[i]    = 1'b1;
                state_d[i] = FULL;
            end else if ((state_q[i] == FULL) && out_ready[i]) begin
                state_d[i] = EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                state_q[i] <= EMPTY;
                data_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                state_q[i] <= state_d[i];
                if (load[i]) begin
                    data_q[i] <= in_data;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < int'(NUM_CH); i++) begin
            out_valid[i] = (state_q[i] == FULL);
        end
    end

    assign out0 = data_q[0];
    assign out1 = data_q[1];
    assign out2 = data_q[2];
    assign out3 = data_q[3];

`ifdef DEMUX2_4_STREAM_CNT_EN
    logic [15:0] cnt_q [NUM_CH];

    // Free-running wrap-around count of accepts per channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (load[i]) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign cnt0 = cnt_q[0];
    assign cnt1 = cnt_q[1];
    assign cnt2 = cnt_q[2];
    assign cnt3 = cnt_q[3];
`endif

endmodule

// File: doc/demux2_4_stream.md
Name: demux2_4_stream

Overview:
- Registered 1-to-4 stream demultiplexer with valid/ready handshake on the input and on each of four outputs.
- It is the distribution counterpart of the 4:1 select mux. One producer stream is steered by a 2-bit select to one of four consumers, such as per-unit result or writeback queues.
- Each output owns a one-entry holding register, so a stalled consumer blocks only its own channel.
- Full throughput of one word per cycle is sustained when the addressed consumer is ready.

Parameters:
- BIT_WIDTH, 32, width of the data word on the input and on every output.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- sel  input  2  destination channel for the current input word; sampled only on accept.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  block can accept the word addressed by sel this cycle.
- in_data  input  BIT_WIDTH  producer word.
- out_valid  output  4  bit i set when channel i holds a word.
- out_ready  input  4  bit i set when consumer i takes the word this cycle.
- out0  output  BIT_WIDTH  channel 0 data.
- out1  output  BIT_WIDTH  channel 1 data.
- out2  output  BIT_WIDTH  channel 2 data.
- out3  output  BIT_WIDTH  channel 3 data.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - out_valid=4'b0000 and out0..out3 all zero.
  - Any held words are discarded, including when reset arrives mid-stream.
  - While rst_n=0, in_ready=0.
- Per-channel state is one slot: EMPTY or FULL.
  - FULL is visible as out_valid[i]=1.
  - outN is driven directly from the slot register; no combinational path from in_data to outN.
- in_ready is combinational:
  - in_ready = rst_n & (~out_valid[sel] | out_ready[sel]).
  - It depends on sel and the addressed out_ready bit only.
- An accept occurs when in_valid & in_ready.
  - Slot[sel] loads in_data at the edge.
  - out_valid[sel] is 1 from the next cycle; latency is one cycle from accept to visibility.
- A drain on channel i occurs when out_valid[i] & out_ready[i].
  - If slot i is not loaded at the same edge, slot i becomes EMPTY.
- Simultaneous drain and accept on the same channel:
  - The slot loads the new word and out_valid stays 1.
  - This gives back-to-back one-word-per-cycle flow with no bubble.
- Drains on other channels in the same cycle as an accept proceed independently.
- Stall: while out_valid[i]=1 and out_ready[i]=0, outN holds its value and out_valid[i] stays 1.
- If in_valid=1 and in_ready=0, nothing is loaded. The producer holds the word.
- in_data and sel are don't-care when in_valid=0. No state changes without an accept or a drain.
- out_ready[i] with out_valid[i]=0 has no effect.
- Ordering is preserved per channel. There is no cross-channel ordering guarantee.

Optional Feature:
- Macro: DEMUX2_4_STREAM_CNT_EN.
- When defined, the block adds output ports cnt0, cnt1, cnt2, cnt3, each 16 bits wide.
  - cntN counts words accepted into channel N.
  - Each counter increments by 1 on the edge of an accept with sel=N.
  - Each counter wraps from 16'hFFFF to 16'h0000.
  - Counters reset to 0 on rst_n=0.
- When not defined, these ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 for 2 cycles with in_valid=1, sel=2, in_data=32'hDEAD_BEEF.
  - Required: in_ready=0 throughout, out_valid=4'b0000, out0..out3=0. After release, in_ready=1.
- Single route:
  - Stimulus: sel=1, in_data=32'h0000_00A5, in_valid=1 for one cycle, out_ready=4'b0000.
  - Required: the next cycle shows out_valid=4'b0010 and out1=32'h0000_00A5. The value holds for 5 stall cycles.
- Blocking:
  - Stimulus: with channel 1 FULL and out_ready[1]=0, present sel=1, in_data=32'h11.
  - Required: in_ready=0 and out1 unchanged.
  - Follow-on stimulus: change to sel=3, in_data=32'h33.
  - Required: in_ready=1, and the next cycle shows out_valid=4'b1010 and out3=32'h33.
- Streaming:
  - Stimulus: sel=0, out_ready[0]=1, words 1..8 on consecutive cycles.
  - Required: in_ready stays 1. out0 shows 1..8 on consecutive cycles starting one cycle after the first accept, with no bubbles.
- Reset mid-operation:
  - Stimulus: fill all four channels (out_valid=4'b1111), then assert rst_n=0 for one cycle.
  - Required: out_valid=4'b0000 and all outputs zero after the edge. Previously held words never reappear.
- Counters (DEMUX2_4_STREAM_CNT_EN defined):
  - Stimulus: preload via 65537 accepts to channel 2.
  - Required: cnt2=16'h0001 after the wrap, and cnt0, cnt1, cnt3 all 0.
